aes_key_schedule: RTL and testbench
===================================

// Module: aes_key_schedule
// PURPOSE
//  Sequential AES-128 key-schedule controller. It accepts a cipher key over a valid/ready handshake.
//  It then iterates the per-round key-expansion block over 10 rounds and stores all 11 round keys.
//  Stored keys are served through an indexed read port to the AES round datapath.
//  Sits between the key register interface (upstream) and the cipher round engine (downstream).
// PARAMETERS
//  KEY_W  128  key / round-key width; only 128 supported
//  NR     10   number of expansion rounds; only 10 supported (rcon table covers rc 0..9)
// PORTS
//  clk          in   1    clock
//  rst_n        in   1    asynchronous active-low reset
//  key_valid_i  in   1    new cipher key offered
//  key_ready_o  out  1    controller can accept a key (IDLE)
//  key_i        in   128  cipher key, word 0 in [127:96]
//  ks_busy_o    out  1    expansion in progress
//  ks_done_o    out  1    all 11 round keys valid; level, held until the next key is accepted
//  rk_idx_i     in   4    round-key index 0..10
//  rk_o         out  128  round key rk[rk_idx_i], registered
// BEHAVIOUR
//  Clock and reset: one clock, clk. rst_n is asynchronous assert, active-low.
//  Reset values: key_ready_o=1, ks_busy_o=0, ks_done_o=0, rk_o=0, rk[0..10]=0, rc=0, state=IDLE.
//  FSM states: IDLE, START, GAP.
//   IDLE
//    - key_ready_o=1.
//    - On key_valid_i&&key_ready_o: rk[0]<=key_i, rc<=0, ks_done_o<=0, ks_busy_o<=1, go to START.
//   START
//    - Drive expander start=1, rc=rc, key=rk[rc].
//    - On finished: rk[rc+1]<=keyout.
//    - If rc==NR-1: ks_busy_o<=0, ks_done_o<=1, go to IDLE.
//    - Else: rc<=rc+1, go to GAP.
//    - If finished is not yet asserted: hold START with all expander inputs stable.
//   GAP
//    - start=0 for exactly one cycle, so the sbox handshake re-arms; then go to START.
//  Latency: with a same-cycle finished, round r is in START on cycle 2r+1 after the accept edge.
//   ks_done_o rises at cycle 20.
//  Handshake: key_ready_o=0 whenever state!=IDLE; key_valid_i is ignored then.
//   A key offered while ks_done_o=1 is accepted, clears ks_done_o and re-expands.
//  Read port
//   - rk_o<=rk[rk_idx_i] every cycle (1-cycle latency).
//   - rk_idx_i>10 gives rk_o<=0.
//   - During expansion only rk[0..rc] are current; consumers must wait for ks_done_o.
//  Width rules: rc is 4 bit and never exceeds NR-1.
//   The expander is driven with start=0 outside START, so its outputs are ignored.
//  Reset mid-expansion: all state, round keys and outputs clear immediately (asynchronous).
//   No partial keys remain.
// CONFIGURATION
//  AES_KS_ZEROIZE_EN defined
//   - Adds input port zeroize_i (1 bit), synchronous and highest priority over every state.
//   - On the next edge: rk[0..10]<=0, rk_o<=0, ks_done_o<=0, ks_busy_o<=0, state<=IDLE.
//   - A concurrent key_valid_i is not accepted.
//  AES_KS_ZEROIZE_EN undefined: no zeroize_i port; keys are cleared only by rst_n.
// STRUCTURE
//  Package aes_pkg
//   - AES_KEY_W=128, AES_NR=10.
//   - typedef logic [127:0] aes_key_t.
//   - typedef enum {KS_IDLE, KS_START, KS_GAP} ks_state_e.
//  Sub-module: one instance of the existing KeyGeneration per-round expander.
//   Connections: start, rc, key=rk[rc], finished, keyout.
//  Everything else (FSM, round counter, 11x128 key store, read mux) is local.
// TESTING
//  1. Key 2b7e151628aed2a6abf7158809cf4f3c:
//     -> rk1=a0fafe1788542cb123a339392a6c7605, rk10=d014f9a8c9ee2589e13f0cc8b6630ca6.
//     -> ks_done_o at cycle 20.
//  2. Key all-zero:
//     -> rk1=62636363626363636263636362636363, rk10=b4ef5bcb3e92e21123e951cf6f8f188e.
//  3. key_valid_i held high through an expansion:
//     -> key_ready_o=0 and busy=1 cycles 1..19; exactly one accept; second key accepted only in IDLE.
//  4. rst_n pulsed low at cycle 7:
//     -> all outputs 0 and key_ready_o=1 immediately; next key expands correctly from rc=0.
//  5. rk_idx_i=11 and 15 -> rk_o=0 one cycle later. rk_idx_i=0 -> rk_o=key_i.
//  6. (AES_KS_ZEROIZE_EN) zeroize_i at cycle 9 with key_valid_i=1:
//     -> next cycle IDLE, done=0, every rk read returns 0.

Source files
------------

// File: rtl/aes_key_schedule_pkg.sv
// Shared AES-128 key-schedule types, sizes and byte-level helpers (S-box, rcon).
package aes_pkg;

    localparam int AES_KEY_W = 128;
    localparam int AES_NR    = 10;

    typedef logic [AES_KEY_W-1:0] aes_key_t;

    typedef enum logic [1:0] {
        KS_IDLE  = 2'd0,
        KS_START = 2'd1,
        KS_GAP   = 2'd2
    } ks_state_e;

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] AES_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] aes_sbox(input logic [7:0] b);
        int idx;
        idx = 255 - int'(b);
        return AES_SBOX[idx*8 +: 8];
    endfunction

    function automatic logic [31:0] aes_sub_word(input logic [31:0] w);
        return {aes_sbox(w[31:24]), aes_sbox(w[23:16]), aes_sbox(w[15:8]), aes_sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] aes_rcon(input logic [3:0] rc);
        logic [7:0] r;
        case (rc)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Key-load handshake and round-key read port between key register block, schedule and round engine.
interface aes_key_schedule_if;
    import aes_pkg::*;

    logic     key_valid_i;
    logic     key_ready_o;
    aes_key_t key_i;
    logic     ks_busy_o;
    logic     ks_done_o;
    logic [3:0] rk_idx_i;
    aes_key_t rk_o;

    modport master (
        output key_valid_i, key_i, rk_idx_i,
        input  key_ready_o, ks_busy_o, ks_done_o, rk_o
    );

    modport slave (
        input  key_valid_i, key_i, rk_idx_i,
        output key_ready_o, ks_busy_o, ks_done_o, rk_o
    );

endinterface

// File: rtl/aes_key_schedule_keygen.sv
// Per-round AES-128 key expander: one round key from the previous one, with a start/finished handshake.
module KeyGeneration
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [3:0] rc_i,
    input  aes_key_t   key_i,
    output logic       finished_o,
    output aes_key_t   keyout_o
);

    logic        armed_q, armed_d;
    logic [31:0] w0, w1, w2, w3, temp, n0, n1, n2, n3;

    // Answers once per start pulse; start must drop for a cycle before the next round.
    assign armed_d    = ~start_i;
    assign finished_o = start_i & armed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) armed_q <= 1'b1;
        else        armed_q <= armed_d;
    end

    assign {w0, w1, w2, w3} = key_i;
    assign temp = aes_sub_word({w3[23:0], w3[31:24]}) ^ {aes_rcon(rc_i), 24'h000000};
    assign n0 = w0 ^ temp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign keyout_o = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_schedule.sv
// AES-128 key-schedule controller: expands a cipher key into 11 stored round keys behind a read port.
// Optional synchronous key wipe (zeroize_i) when AES_KS_ZEROIZE_EN is defined.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int KEY_W = AES_KEY_W,
    parameter int NR    = AES_NR
) (
    input  logic clk,
    input  logic rst_n,
`ifdef AES_KS_ZEROIZE_EN
    input  logic zeroize_i,
`endif
    aes_key_schedule_if.slave ks
);

    localparam logic [1:0] ST_IDLE  = KS_IDLE;
    localparam logic [1:0] ST_START = KS_START;
    localparam logic [1:0] ST_GAP   = KS_GAP;
    localparam logic [3:0] RC_LAST  = 4'(NR - 1);
    localparam logic [3:0] IDX_MAX  = 4'(NR);
    localparam int         NK       = NR + 1;

    logic [1:0]       state_q, state_d;
    logic [3:0]       rc_q, rc_d, rc_nxt;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [KEY_W-1:0] rk_q [NK];
    logic [KEY_W-1:0] rk_d [NK];
    logic [KEY_W-1:0] rko_q, rko_d;

    logic     xp_start, xp_finished;
    aes_key_t xp_keyout;

    assign rc_nxt = rc_q + 4'd1;

    KeyGeneration u_keygen (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (xp_start),
        .rc_i      (rc_q),
        .key_i     (rk_q[rc_q]),
        .finished_o(xp_finished),
        .keyout_o  (xp_keyout)
    );

    always_comb begin
        state_d  = state_q;
        rc_d     = rc_q;
        busy_d   = busy_q;
        done_d   = done_q;
        rk_d     = rk_q;
        xp_start = 1'b0;
        rko_d    = (ks.rk_idx_i <= IDX_MAX) ? rk_q[ks.rk_idx_i] : '0;

        case (state_q)
            ST_IDLE: begin
                if (ks.key_valid_i) begin
                    rk_d[0] = ks.key_i;
                    rc_d    = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                xp_start = 1'b1;
                if (xp_finished) begin
                    rk_d[rc_nxt] = xp_keyout;
                    if (rc_q == RC_LAST) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        rc_d    = rc_nxt;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP:  state_d = ST_START;
            default: state_d = ST_IDLE;
        endcase

`ifdef AES_KS_ZEROIZE_EN
        // Wipe overrides everything, including a key accept in the same cycle.
        if (zeroize_i) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            rk_d    = '{default: '0};
            rko_d   = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rc_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rk_q    <= '{default: '0};
            rko_q   <= '0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rk_q    <= rk_d;
            rko_q   <= rko_d;
        end
    end

    assign ks.key_ready_o = (state_q == ST_IDLE);
    assign ks.ks_busy_o   = busy_q;
    assign ks.ks_done_o   = done_q;
    assign ks.rk_o        = rko_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule using FIPS-197 key-expansion vectors.
module tb_aes_key_schedule;
    import aes_pkg::*;

    localparam aes_key_t KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam aes_key_t RK1_A   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam aes_key_t RK10_A  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam aes_key_t KEY_Z   = 128'h0;
    localparam aes_key_t RK1_Z   = 128'h62636363626363636263636362636363;
    localparam aes_key_t RK10_Z  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
`ifdef AES_KS_ZEROIZE_EN
    logic zeroize = 1'b0;
`endif
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    aes_key_schedule_if ksif ();

    aes_key_schedule dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef AES_KS_ZEROIZE_EN
        .zeroize_i(zeroize),
`endif
        .ks       (ksif)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_rk(input logic [3:0] idx, output aes_key_t v);
        ksif.rk_idx_i = idx;
        tick();
        v = ksif.rk_o;
    endtask

    task automatic offer_key(input aes_key_t k);
        ksif.key_i       = k;
        ksif.key_valid_i = 1'b1;
        tick();
        ksif.key_valid_i = 1'b0;
    endtask

    // Cycle 1 is the cycle right after the accept edge.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (ksif.ks_done_o !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (ksif.key_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b want 1", ksif.key_ready_o); end
        total++;
        if (ksif.ks_busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", ksif.ks_busy_o); end
        total++;
        if (ksif.ks_done_o !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", ksif.ks_done_o); end
        total++;
        if (ksif.rk_o !== '0) begin bad++; $display("FAIL reset_rk: got %h want 0", ksif.rk_o); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_vector_a();
        int cyc;
        aes_key_t v;
        offer_key(KEY_A);
        total++;
        if (ksif.ks_busy_o !== 1'b1 || ksif.key_ready_o !== 1'b0) begin
            bad++; $display("FAIL a_accept: busy=%0b ready=%0b want busy=1 ready=0", ksif.ks_busy_o, ksif.key_ready_o);
        end
        wait_done(cyc);
        total++;
        if (cyc != 20) begin bad++; $display("FAIL a_done_cycle: got %0d want 20", cyc); end
        read_rk(4'd0, v);
        total++;
        if (v !== KEY_A) begin bad++; $display("FAIL a_rk0: got %h want %h", v, KEY_A); end
        read_rk(4'd1, v);
        total++;
        if (v !== RK1_A) begin bad++; $display("FAIL a_rk1: got %h want %h", v, RK1_A); end
        read_rk(4'd10, v);
        total++;
        if (v !== RK10_A) begin bad++; $display("FAIL a_rk10: got %h want %h", v, RK10_A); end
    endtask

    task automatic test_zero_key();
        int cyc;
        aes_key_t v;
        offer_key(KEY_Z);
        wait_done(cyc);
        total++;
        if (cyc != 20) begin bad++; $display("FAIL z_done_cycle: got %0d want 20", cyc); end
        read_rk(4'd1, v);
        total++;
        if (v !== RK1_Z) begin bad++; $display("FAIL z_rk1: got %h want %h", v, RK1_Z); end
        read_rk(4'd10, v);
        total++;
        if (v !== RK10_Z) begin bad++; $display("FAIL z_rk10: got %h want %h", v, RK10_Z); end
    endtask

    task automatic test_back_to_back();
        int errs = 0;
        int cyc;
        aes_key_t v;
        ksif.rk_idx_i    = 4'd0;
        ksif.key_i       = KEY_A;
        ksif.key_valid_i = 1'b1;
        tick();
        ksif.key_i = KEY_Z;
        for (int c = 1; c <= 19; c++) begin
            if (ksif.key_ready_o !== 1'b0 || ksif.ks_busy_o !== 1'b1 || ksif.ks_done_o !== 1'b0) errs++;
            tick();
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL b2b_busy_window: bad cycles=%0d want 0", errs); end
        total++;
        if (ksif.ks_done_o !== 1'b1 || ksif.key_ready_o !== 1'b1 || ksif.ks_busy_o !== 1'b0) begin
            bad++; $display("FAIL b2b_done20: done=%0b ready=%0b busy=%0b want 1 1 0", ksif.ks_done_o, ksif.key_ready_o, ksif.ks_busy_o);
        end
        total++;
        if (ksif.rk_o !== KEY_A) begin bad++; $display("FAIL b2b_single_accept: rk0 got %h want %h", ksif.rk_o, KEY_A); end
        tick();
        ksif.key_valid_i = 1'b0;
        total++;
        if (ksif.ks_busy_o !== 1'b1 || ksif.ks_done_o !== 1'b0) begin
            bad++; $display("FAIL b2b_second_accept: busy=%0b done=%0b want 1 0", ksif.ks_busy_o, ksif.ks_done_o);
        end
        wait_done(cyc);
        read_rk(4'd10, v);
        total++;
        if (v !== RK10_Z) begin bad++; $display("FAIL b2b_rk10: got %h want %h", v, RK10_Z); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        aes_key_t v;
        offer_key(KEY_A);
        repeat (6) tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (ksif.key_ready_o !== 1'b1 || ksif.ks_busy_o !== 1'b0 || ksif.ks_done_o !== 1'b0 || ksif.rk_o !== '0) begin
            bad++; $display("FAIL mid_reset_outputs: ready=%0b busy=%0b done=%0b rk=%h want 1 0 0 0",
                            ksif.key_ready_o, ksif.ks_busy_o, ksif.ks_done_o, ksif.rk_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        read_rk(4'd0, v);
        total++;
        if (v !== '0) begin bad++; $display("FAIL mid_rk0_cleared: got %h want 0", v); end
        read_rk(4'd1, v);
        total++;
        if (v !== '0) begin bad++; $display("FAIL mid_rk1_cleared: got %h want 0", v); end
        offer_key(KEY_A);
        wait_done(cyc);
        total++;
        if (cyc != 20) begin bad++; $display("FAIL mid_done_cycle: got %0d want 20", cyc); end
        read_rk(4'd1, v);
        total++;
        if (v !== RK1_A) begin bad++; $display("FAIL mid_rk1: got %h want %h", v, RK1_A); end
        read_rk(4'd10, v);
        total++;
        if (v !== RK10_A) begin bad++; $display("FAIL mid_rk10: got %h want %h", v, RK10_A); end
    endtask

    task automatic test_read_port();
        aes_key_t v;
        read_rk(4'd11, v);
        total++;
        if (v !== '0) begin bad++; $display("FAIL idx11: got %h want 0", v); end
        read_rk(4'd15, v);
        total++;
        if (v !== '0) begin bad++; $display("FAIL idx15: got %h want 0", v); end
        read_rk(4'd0, v);
        total++;
        if (v !== KEY_A) begin bad++; $display("FAIL idx0: got %h want %h", v, KEY_A); end
        total++;
        if (ksif.ks_done_o !== 1'b1) begin bad++; $display("FAIL done_held: got %0b want 1", ksif.ks_done_o); end
    endtask

`ifdef AES_KS_ZEROIZE_EN
    task automatic test_zeroize();
        int errs = 0;
        aes_key_t v;
        offer_key(KEY_A);
        repeat (8) tick();
        zeroize          = 1'b1;
        ksif.key_i       = KEY_Z;
        ksif.key_valid_i = 1'b1;
        tick();
        zeroize          = 1'b0;
        ksif.key_valid_i = 1'b0;
        total++;
        if (ksif.key_ready_o !== 1'b1 || ksif.ks_busy_o !== 1'b0 || ksif.ks_done_o !== 1'b0 || ksif.rk_o !== '0) begin
            bad++; $display("FAIL zeroize_state: ready=%0b busy=%0b done=%0b rk=%h want 1 0 0 0",
                            ksif.key_ready_o, ksif.ks_busy_o, ksif.ks_done_o, ksif.rk_o);
        end
        for (int i = 0; i <= 10; i++) begin
            read_rk(4'(i), v);
            if (v !== '0) errs++;
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL zeroize_store: nonzero keys=%0d want 0", errs); end
        total++;
        if (ksif.ks_busy_o !== 1'b0) begin bad++; $display("FAIL zeroize_no_accept: busy=%0b want 0", ksif.ks_busy_o); end
    endtask
`endif

    initial begin
        ksif.key_valid_i = 1'b0;
        ksif.key_i       = '0;
        ksif.rk_idx_i    = 4'd0;
        test_reset();
        test_vector_a();
        test_zero_key();
        test_back_to_back();
        test_reset_mid();
        test_read_port();
`ifdef AES_KS_ZEROIZE_EN
        test_zeroize();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
